// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU controller: widths, cycle count,
// FSM encoding and the operand magnitude helper.
package div_ctrl_pkg;
    localparam int OP_W       = 32;
    localparam int RES_W      = 64;
    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    // Magnitude of a signed operand; 0x80000000 maps onto itself, read as unsigned.
    function automatic logic [OP_W-1:0] abs_val(input logic [OP_W-1:0] v, input logic sgn);
        return (sgn && v[OP_W-1]) ? (~v + 1'b1) : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not borrow.
module div_step
    import div_ctrl_pkg::*;
(
    input  logic [OP_W:0]   part,
    input  logic [OP_W-1:0] divisor,
    output logic [OP_W-1:0] rem_next,
    output logic            q_bit
);
    logic [OP_W:0] diff;
    logic          unused_msb;

    assign q_bit      = (part >= {1'b0, divisor});
    assign diff       = part - {1'b0, divisor};
    // The remainder stays below the divisor, so the difference MSB is always 0 when kept.
    assign unused_msb = diff[OP_W];
    assign rem_next   = q_bit ? diff[OP_W-1:0] : part[OP_W-1:0];
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU unit: 32 restoring steps, sign fix-up at completion.
// Optional DIV_ZERO_FLAG_EN adds a div_zero output flagging a zero divisor in END.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_div,
    input  logic [OP_W-1:0]   opdata1,
    input  logic [OP_W-1:0]   opdata2,
    input  logic              annul,
    output logic [RES_W-1:0]  result,
    output logic              ready,
`ifdef DIV_ZERO_FLAG_EN
    output logic              stall,
    output logic              div_zero
`else
    output logic              stall
`endif
);
    state_t            state, nstate;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   dvd, dsr, rem;
    logic              neg_q, neg_r, dz;
    logic              accept, last;
    logic [OP_W-1:0]   rem_next, q_next;
    logic              q_bit;

    assign accept = (state == S_IDLE) && start && !annul;
    assign last   = (cnt == CNT_W'(DIV_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nstate;
            cnt   <= (state == S_ON && !annul) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        nstate = state;
        if (annul) begin
            nstate = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start) nstate = (opdata2 == '0) ? S_DIVZERO : S_ON;
                S_DIVZERO: nstate = S_END;
                S_ON:      if (last) nstate = S_END;
                S_END:     nstate = S_IDLE;
                default:   nstate = S_IDLE;
            endcase
        end
    end

    // Dividend register shifts left each step, its vacated LSBs collecting the quotient.
    div_step u_step (
        .part     ({rem, dvd[OP_W-1]}),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
    assign q_next = {dvd[OP_W-2:0], q_bit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            result <= '0;
        end else if (accept) begin
            dvd    <= abs_val(opdata1, signed_div);
            dsr    <= abs_val(opdata2, signed_div);
            rem    <= '0;
            neg_q  <= signed_div & (opdata1[OP_W-1] ^ opdata2[OP_W-1]);
            neg_r  <= signed_div & opdata1[OP_W-1];
            dz     <= (opdata2 == '0);
        end else if (state == S_ON && !annul) begin
            dvd <= q_next;
            rem <= rem_next;
            if (last)
                result <= {neg_r ? (~rem_next + 1'b1) : rem_next,
                           neg_q ? (~q_next + 1'b1) : q_next};
        end else if (state == S_DIVZERO && !annul) begin
            result <= '0;
        end
    end

    assign ready = (state == S_END);
    assign stall = resetn && (accept || state == S_DIVZERO || state == S_ON);
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero = (state == S_END) && dz;
`endif
endmodule
